// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART with TX FIFO, status and baud-divisor registers.
// Define MMIO_UART_RX_EN to build the receiver, RXDATA and the RX status/irq terms.
module mmio_uart #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_n,
  input  logic [3:0]  oe_n,
  input  logic [3:0]  we_n,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        dout_en_n,
  output logic        txd,
  input  logic        rxd,
  output logic        irq_n
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  logic        wr_acc;
  logic        rd_acc;
  logic        w1c;
  logic [15:0] divisor;
  logic [15:0] div_eff;
  logic [31:0] rdata;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_idle;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          tx_ovf;

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;

  logic        rx_valid;
  logic        rx_overrun;
  logic        rx_frame_err;
  logic [7:0]  rx_byte;
  logic        unused_din;

  assign wr_acc    = !ce_n && (we_n != 4'hF);
  assign rd_acc    = !ce_n && (oe_n != 4'hF) && !wr_acc;
  assign dout_en_n = !(!ce_n && (oe_n != 4'hF));
  assign w1c       = wr_acc && (addr == 2'd1) && !we_n[0];
  assign div_eff   = (divisor == 16'd0) ? 16'd1 : divisor;
  assign unused_din = ^din[31:16];

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor <= DIV_RESET;
    end else if (wr_acc && addr == 2'd2) begin
      if (!we_n[0]) divisor[7:0]  <= din[7:0];
      if (!we_n[1]) divisor[15:8] <= din[15:8];
    end
  end

  assign tx_full  = (count == CW'(FIFO_DEPTH));
  assign tx_empty = (count == '0);
  assign tx_idle  = tx_empty && (tx_state == TX_IDLE);
  assign push_req = wr_acc && (addr == 2'd0) && !we_n[0];
  assign pop      = (tx_state == TX_IDLE) && !tx_empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok  = push_req && (!tx_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wptr] <= din[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf <= 1'b0;
    end else if (push_req && !push_ok) begin
      tx_ovf <= 1'b1;
    end else if (w1c && din[4]) begin
      tx_ovf <= 1'b0;
    end
  end

  // Each bit reloads its length, so divisor changes land on bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      txd <= (tx_state == TX_START) ? 1'b0 :
             (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
      unique case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            tx_shift <= fifo_mem[rptr];
            tx_cnt   <= div_eff - 16'd1;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == 16'd0) begin
            tx_bit   <= '0;
            tx_cnt   <= div_eff - 16'd1;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            tx_cnt   <= div_eff - 16'd1;
            if (tx_bit == 3'd7) tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

`ifdef MMIO_UART_RX_EN
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t   rx_state;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_q;
  logic        rx_done;
  logic        rx_stop_hit;
  logic        rd_rx;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  assign rd_rx       = rd_acc && (addr == 2'd3);
  assign rx_stop_hit = (rx_state == RX_STOP) && (rx_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_q     <= 1'b1;
      rx_done  <= 1'b0;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_q    <= rx_s2;
      rx_done <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          if (!rx_s2 && rx_q) begin
            rx_cnt   <= div_eff >> 1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else if (rx_s2) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_bit   <= '0;
            rx_cnt   <= div_eff - 16'd1;
            rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            rx_cnt   <= div_eff - 16'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == 16'd0) begin
            rx_done  <= rx_s2;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_byte      <= '0;
    end else begin
      if (rx_done) begin
        rx_valid <= 1'b1;
        rx_byte  <= rx_shift;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end
      if (rx_done && rx_valid && !rd_rx) begin
        rx_overrun <= 1'b1;
      end else if (w1c && din[3]) begin
        rx_overrun <= 1'b0;
      end
      if (rx_stop_hit && !rx_s2) begin
        rx_frame_err <= 1'b1;
      end else if (w1c && din[5]) begin
        rx_frame_err <= 1'b0;
      end
    end
  end
`else
  logic unused_rx;

  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_byte      = '0;
  assign unused_rx    = rxd ^ rd_acc;
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      2'd1:    rdata = {26'd0, rx_frame_err, tx_ovf, rx_overrun,
                        rx_valid, tx_idle, tx_full};
      2'd2:    rdata = {16'd0, divisor};
      2'd3:    rdata = {24'd0, rx_byte};
      default: rdata = '0;
    endcase
  end

  assign dout  = dout_en_n ? 32'd0 : rdata;
  assign irq_n = !(tx_idle || rx_valid);

endmodule
